regbank_writeback: RTL and testbench
====================================

REGBANK_WRITEBACK -- requirements
Module: regbank_writeback

Interface
REQ-001 Parameter QDEPTH, default 4, depth of load-result queue; power of two, 2..16.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 alu_we  in  1  ALU result write request, single-cycle, never stalled.
REQ-005 alu_addr  in  4  ALU destination register.
REQ-006 alu_data  in  32  ALU result.
REQ-007 mem_issue  in  1  load issued this cycle; reserves destination register.
REQ-008 mem_issue_addr  in  4  destination register of issued load.
REQ-009 mem_valid  in  1  load result offered by memory unit.
REQ-010 mem_addr  in  4  destination register of offered result.
REQ-011 mem_data  in  32  loaded data.
REQ-012 mem_ready  out  1  load result accepted when mem_valid and mem_ready both high.
REQ-013 addr_a, addr_b  in  4 each  register-bank read addresses to hazard-check.
REQ-014 hazard_a, hazard_b  out  1 each  read address has an outstanding load.
REQ-015 we  out  1  register-bank write enable.
REQ-016 addr_d  out  4  register-bank write address.
REQ-017 data_d  out  32  register-bank write data.
REQ-018 err  out  1  sticky protocol-error flag.

Function
REQ-019 we, addr_d, data_d SHALL be registered; a write selected in cycle N appears in cycle N+1 for exactly one cycle.
REQ-020 Selection priority per cycle: alu_we first, else queue head if queue non-empty, else no write (we=0).
REQ-021 Queue SHALL be FIFO of {addr,data}, QDEPTH entries, with read/write pointers wrapping modulo QDEPTH and a count of width clog2(QDEPTH)+1.
REQ-022 mem_ready SHALL be combinational: high when count<QDEPTH, or when count==QDEPTH and the head is popped this cycle.
REQ-023 Accepted load results SHALL always enter the queue; minimum load-result-to-we latency is 2 cycles (accept N, pop N+1, we N+2).
REQ-024 Simultaneous push and pop SHALL leave count unchanged; push into empty queue is not poppable in the same cycle.
REQ-025 Destination register 0 (ALU or queue): entry consumed/selected normally but we SHALL stay 0.
REQ-026 Scoreboard: 16-bit busy vector; mem_issue with mem_issue_addr!=0 sets busy[mem_issue_addr] next cycle.
REQ-027 busy[addr_d] SHALL clear in the cycle the queue-sourced write is presented on we; ALU writes SHALL NOT clear busy.
REQ-028 Same-cycle set and clear of the same register: set wins.
REQ-029 hazard_a = busy[addr_a] and addr_a!=0; same for b; combinational from busy.
REQ-030 err SHALL set and hold until reset on: mem_issue to an already-busy register without same-cycle clear; alu_we to a busy register; mem_valid accepted for a non-busy register.
REQ-031 Protocol errors SHALL not corrupt queue or scoreboard beyond the single offending operation.

Reset
REQ-032 On reset: queue empty, pointers 0, busy=0, we=0, addr_d=0, data_d=0, err=0; mem_ready=1 first cycle after reset.
REQ-033 Reset mid-operation SHALL discard queued results and outstanding reservations; no write issued in the cycle after reset.

Structure
REQ-034 Shared CPU package SHALL hold register-address width (4), data width (32) and register count (16).
REQ-035 Queue SHALL be one sub-module, wb_fifo (push/pop/full/empty/count), instantiated once.

Verification
REQ-036 Issue load r5, mem_valid r5=0xDEADBEEF at cycle 3 -> hazard_a high for addr_a=5 from cycle 1, we/addr_d=5/data_d=0xDEADBEEF at cycle 5, hazard low cycle 5.
REQ-037 alu_we r3=7 every cycle while load result r4 queued -> r4 write held until first idle ALU cycle, then written next cycle.
REQ-038 Fill queue with 4 results under continuous ALU writes -> mem_ready low on 5th; single ALU gap -> head popped, mem_ready high same cycle, order preserved.
REQ-039 alu_we r0=0x55 and load result r0 -> we never asserted, queue drains, err stays 0.
REQ-040 mem_issue r6 twice without completion -> err=1 and remains 1 until reset.
REQ-041 Reset with 3 queued results and busy r1,r2 -> no writes after reset, hazards 0, mem_ready 1.

Source files
------------

// File: rtl/regbank_writeback_pkg.sv
`default_nettype none
// ============================================================================
// regbank_writeback_pkg
//   Shared CPU constants and the queued write-back entry type.
//   Revision: 1.0
// ============================================================================
package regbank_writeback_pkg;

    localparam int REG_AW   = 4;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int WB_W     = REG_AW + DATA_W;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// wb_fifo
//   Power-of-two FIFO holding load results waiting for a write-back slot.
//   Revision: 1.0
// ============================================================================
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_pop_ok  = pop && !empty;
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign w_push_ok = push && (!full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/regbank_writeback.sv
`default_nettype none
// ============================================================================
// regbank_writeback
//   Register-bank write-back arbiter: ALU writes take priority over queued
//   load results; a busy scoreboard flags read hazards and protocol errors.
//   Revision: 1.0
// ============================================================================
module regbank_writeback
    import regbank_writeback_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_we,
    input  logic [REG_AW-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_issue,
    input  logic [REG_AW-1:0] mem_issue_addr,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic [REG_AW-1:0] addr_a,
    input  logic [REG_AW-1:0] addr_b,
    output logic              hazard_a,
    output logic              hazard_b,
    output logic              we,
    output logic [REG_AW-1:0] addr_d,
    output logic [DATA_W-1:0] data_d,
    output logic              err
);

    localparam int CW = $clog2(QDEPTH) + 1;

    wb_entry_t         w_head;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic              w_pop;
    logic              w_accept;
    logic              w_clr_hit;
    logic              w_err_now;
    logic [NUM_REGS-1:0] w_busy_nxt;

    logic [NUM_REGS-1:0] r_busy;
    logic              r_we;
    logic [REG_AW-1:0] r_addr_d;
    logic [DATA_W-1:0] r_data_d;
    logic              r_err;

    // The queue only gets the write port on cycles the ALU leaves idle.
    assign w_pop     = !alu_we && !w_empty;
    assign mem_ready = (w_count < CW'(QDEPTH)) || (w_full && w_pop);
    assign w_accept  = mem_valid && mem_ready;

    wb_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (WB_W)
    ) u_wb_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_accept),
        .push_data ({mem_addr, mem_data}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign w_clr_hit = w_pop && (w_head.addr == mem_issue_addr);
    assign w_err_now = (mem_issue && (mem_issue_addr != '0) && r_busy[mem_issue_addr] && !w_clr_hit)
                     || (alu_we && r_busy[alu_addr])
                     || (w_accept && (mem_addr != '0) && !r_busy[mem_addr]);

    // Clear first so that a reservation made in the same cycle survives.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) begin
            w_busy_nxt[w_head.addr] = 1'b0;
        end
        if (mem_issue && (mem_issue_addr != '0)) begin
            w_busy_nxt[mem_issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= '0;
            r_err    <= 1'b0;
            r_we     <= 1'b0;
            r_addr_d <= '0;
            r_data_d <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_err  <= r_err || w_err_now;
            if (alu_we) begin
                r_we     <= (alu_addr != '0);
                r_addr_d <= alu_addr;
                r_data_d <= alu_data;
            end else if (w_pop) begin
                r_we     <= (w_head.addr != '0);
                r_addr_d <= w_head.addr;
                r_data_d <= w_head.data;
            end else begin
                r_we     <= 1'b0;
            end
        end
    end

    assign hazard_a = r_busy[addr_a] && (addr_a != '0);
    assign hazard_b = r_busy[addr_b] && (addr_b != '0);
    assign we       = r_we;
    assign addr_d   = r_addr_d;
    assign data_d   = r_data_d;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_regbank_writeback.sv
`default_nettype none
// ============================================================================
// tb_regbank_writeback
//   Directed scenarios plus randomized traffic against a queue-based model.
//   Revision: 1.0
// ============================================================================
module tb_regbank_writeback;

    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_we;
    logic [3:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mem_issue;
    logic [3:0]  mem_issue_addr;
    logic        mem_valid;
    logic [3:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [3:0]  addr_a;
    logic [3:0]  addr_b;
    logic        hazard_a;
    logic        hazard_b;
    logic        we;
    logic [3:0]  addr_d;
    logic [31:0] data_d;
    logic        err;

    always #5 clk = ~clk;

    regbank_writeback #(.QDEPTH(QD)) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_we         (alu_we),
        .alu_addr       (alu_addr),
        .alu_data       (alu_data),
        .mem_issue      (mem_issue),
        .mem_issue_addr (mem_issue_addr),
        .mem_valid      (mem_valid),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_ready      (mem_ready),
        .addr_a         (addr_a),
        .addr_b         (addr_b),
        .hazard_a       (hazard_a),
        .hazard_b       (hazard_b),
        .we             (we),
        .addr_d         (addr_d),
        .data_d         (data_d),
        .err            (err)
    );

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    bit [15:0]   mbusy;
    bit          merr;
    bit          mwe;
    logic [3:0]  mad;
    logic [31:0] mdd;
    bit          mvalid = 1'b0;
    int          outst[$];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs sampled at the edge.
    function automatic void model_step();
        bit   pop;
        bit   acc;
        ent_t h;
        if (reset) begin
            mq.delete();
            outst.delete();
            mbusy  = '0;
            merr   = 1'b0;
            mwe    = 1'b0;
            mad    = '0;
            mdd    = '0;
            mvalid = 1'b1;
            return;
        end
        pop = !alu_we && (mq.size() > 0);
        acc = mem_valid && ((mq.size() < QD) || pop);
        h   = '{4'd0, 32'd0};
        if (pop) h = mq[0];
        if (mem_issue && mem_issue_addr != 0 && mbusy[mem_issue_addr]
            && !(pop && h.a == mem_issue_addr)) merr = 1'b1;
        if (alu_we && mbusy[alu_addr]) merr = 1'b1;
        if (acc && mem_addr != 0 && !mbusy[mem_addr]) merr = 1'b1;
        if (alu_we) begin
            mwe = (alu_addr != 0);
            mad = alu_addr;
            mdd = alu_data;
        end else if (pop) begin
            void'(mq.pop_front());
            mwe = (h.a != 0);
            mad = h.a;
            mdd = h.d;
            mbusy[h.a] = 1'b0;
        end else begin
            mwe = 1'b0;
        end
        if (mem_issue && mem_issue_addr != 0) mbusy[mem_issue_addr] = 1'b1;
        if (acc) begin
            mq.push_back('{mem_addr, mem_data});
            for (int i = 0; i < outst.size(); i++) begin
                if (outst[i] == int'(mem_addr)) begin
                    outst.delete(i);
                    break;
                end
            end
        end
    endfunction

    task automatic compare();
        bit exp_ready;
        if (!mvalid) return;
        exp_ready = (mq.size() < QD) || (mq.size() > 0 && !alu_we);
        chk("we", we, mwe);
        if (mwe) begin
            chk("addr_d", addr_d, mad);
            chk("data_d", data_d, mdd);
        end
        chk("err", err, merr);
        chk("mem_ready", mem_ready, exp_ready);
        chk("hazard_a", hazard_a, mbusy[addr_a] && addr_a != 0);
        chk("hazard_b", hazard_b, mbusy[addr_b] && addr_b != 0);
    endtask

    // Called just after a falling edge with this cycle's inputs applied.
    task automatic step();
        #1;
        compare();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        alu_we    = 1'b0;
        mem_issue = 1'b0;
        mem_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        alu_addr = '0; alu_data = '0; mem_issue_addr = '0;
        mem_addr = '0; mem_data = '0; addr_a = '0; addr_b = '0;
        idle();
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_we", we, 0);
        chk("rst_addr_d", addr_d, 0);
        chk("rst_data_d", data_d, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_ready", mem_ready, 1);

        // Load r5, result at cycle 3, write-back at cycle 5
        mem_issue = 1'b1; mem_issue_addr = 4'd5; addr_a = 4'd5;
        step();
        mem_issue = 1'b0;
        chk("t36_haz_c1", hazard_a, 1);
        step();
        step();
        mem_valid = 1'b1; mem_addr = 4'd5; mem_data = 32'hDEADBEEF;
        step();
        mem_valid = 1'b0;
        chk("t36_we_c4", we, 0);
        chk("t36_haz_c4", hazard_a, 1);
        step();
        chk("t36_we_c5", we, 1);
        chk("t36_addr_c5", addr_d, 5);
        chk("t36_data_c5", data_d, 32'hDEADBEEF);
        chk("t36_haz_c5", hazard_a, 0);
        step();
        chk("t36_we_c6", we, 0);

        // ALU hogs the port while r4 waits
        mem_issue = 1'b1; mem_issue_addr = 4'd4;
        step();
        mem_issue = 1'b0;
        alu_we = 1'b1; alu_addr = 4'd3; alu_data = 32'd7;
        mem_valid = 1'b1; mem_addr = 4'd4; mem_data = 32'h44;
        step();
        mem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t37_alu_addr", addr_d, 3);
            chk("t37_alu_data", data_d, 7);
        end
        alu_we = 1'b0;
        step();
        chk("t37_ld_we", we, 1);
        chk("t37_ld_addr", addr_d, 4);
        chk("t37_ld_data", data_d, 32'h44);

        // Fill queue under continuous ALU traffic, then one ALU gap
        for (int r = 1; r <= 5; r++) begin
            mem_issue = 1'b1; mem_issue_addr = 4'(r);
            step();
        end
        mem_issue = 1'b0;
        alu_we = 1'b1; alu_addr = 4'd7;
        for (int r = 1; r <= 4; r++) begin
            alu_data = 32'(r);
            mem_valid = 1'b1; mem_addr = 4'(r); mem_data = 32'h100 + 32'(r);
            step();
        end
        mem_addr = 4'd5; mem_data = 32'h105;
        #1;
        chk("t38_ready_full", mem_ready, 0);
        step();
        alu_we = 1'b0;
        #1;
        chk("t38_ready_gap", mem_ready, 1);
        step();
        mem_valid = 1'b0;
        chk("t38_first_addr", addr_d, 1);
        for (int r = 2; r <= 5; r++) begin
            step();
            chk("t38_order_addr", addr_d, r);
            chk("t38_order_data", data_d, 32'h100 + 32'(r));
        end
        step();
        chk("t38_drained_we", we, 0);
        chk("t38_err", err, 0);

        // Register 0 writes are consumed silently
        alu_we = 1'b1; alu_addr = 4'd0; alu_data = 32'h55;
        mem_valid = 1'b1; mem_addr = 4'd0; mem_data = 32'h66;
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t39_we", we, 0);
        end
        chk("t39_err", err, 0);
        chk("t39_ready", mem_ready, 1);

        // Double issue of r6 is a sticky error
        mem_issue = 1'b1; mem_issue_addr = 4'd6;
        step();
        step();
        idle();
        chk("t40_err_set", err, 1);
        for (int i = 0; i < 3; i++) step();
        chk("t40_err_hold", err, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t40_err_clr", err, 0);

        // Reset while results are queued and registers reserved
        for (int r = 1; r <= 3; r++) begin
            mem_issue = 1'b1; mem_issue_addr = 4'(r);
            step();
        end
        mem_issue = 1'b0;
        alu_we = 1'b1; alu_addr = 4'd8;
        for (int r = 1; r <= 3; r++) begin
            mem_valid = 1'b1; mem_addr = 4'(r); mem_data = 32'h200 + 32'(r);
            step();
        end
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        addr_a = 4'd1; addr_b = 4'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t41_haz_a", hazard_a, 0);
            chk("t41_haz_b", hazard_b, 0);
            chk("t41_ready", mem_ready, 1);
            step();
            chk("t41_we", we, 0);
        end

        // Randomized traffic, mostly protocol-clean with rare violations
        for (int n = 0; n < 3000; n++) begin
            int a;
            idle();
            reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 1) == 1) begin
                alu_we = 1'b1;
                alu_addr = 4'($urandom_range(0, 15));
                alu_data = $urandom;
                if (mbusy[alu_addr] && $urandom_range(0, 99) != 0) alu_addr = 4'd0;
            end
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom_range(1, 15);
                if (!mbusy[a] || $urandom_range(0, 199) == 0) begin
                    mem_issue = 1'b1;
                    mem_issue_addr = 4'(a);
                    if (!mbusy[a]) outst.push_back(a);
                end
            end
            if (outst.size() > 0 && $urandom_range(0, 2) != 0) begin
                mem_valid = 1'b1;
                mem_addr = 4'(outst[$urandom_range(0, outst.size() - 1)]);
                mem_data = $urandom;
            end else if ($urandom_range(0, 299) == 0) begin
                mem_valid = 1'b1;
                mem_addr = 4'($urandom_range(0, 15));
                mem_data = $urandom;
            end
            addr_a = 4'($urandom_range(0, 15));
            addr_b = 4'($urandom_range(0, 15));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
